// File: rtl/draw_pkg.sv
// Shared widths, pixel/colour types and the position clamp helper.
package draw_pkg;

  localparam int unsigned POS_W = 12;
  localparam int unsigned RGB_W = 12;

  typedef logic [POS_W-1:0] spr_pos_t;
  typedef logic [RGB_W-1:0] rgb_t;

  // Limit a requested edge so the object never runs off the visible area.
  function automatic spr_pos_t clamp_pos(input spr_pos_t val, input spr_pos_t lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA raster bundle: timing counters, sync/blank strobes and pixel colour.
interface vga_if;
  import draw_pkg::*;

  spr_pos_t hcount;
  spr_pos_t vcount;
  logic     hsync;
  logic     vsync;
  logic     hblnk;
  logic     vblnk;
  rgb_t     rgb;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/sprite_hit.sv
// Window test for one object against the current raster position.
module sprite_hit
  import draw_pkg::*;
#(
  parameter int unsigned WIDTH  = 48,
  parameter int unsigned HEIGHT = 64
) (
  input  logic     en,
  input  spr_pos_t hcount,
  input  spr_pos_t vcount,
  input  spr_pos_t sx,
  input  spr_pos_t sy,
  input  logic     hblnk,
  input  logic     vblnk,
  output logic     hit_c
);

  localparam spr_pos_t W_EXT = POS_W'(WIDTH);
  localparam spr_pos_t H_EXT = POS_W'(HEIGHT);

  // Clamped positions keep these sums inside 12 bits.
  spr_pos_t x_end_c;
  spr_pos_t y_end_c;

  assign x_end_c = sx + W_EXT;
  assign y_end_c = sy + H_EXT;

  assign hit_c = en & (hcount >= sx) & (hcount < x_end_c)
               & (vcount >= sy) & (vcount < y_end_c)
               & ~hblnk & ~vblnk;

endmodule

// File: rtl/draw_sprites.sv
// Overlays up to N_SPR solid rectangles on a VGA stream with 2-cycle latency,
// frame-synchronous position updates and per-frame collision reporting.
module draw_sprites
  import draw_pkg::*;
#(
  parameter int unsigned N_SPR    = 4,
  parameter int unsigned WIDTH    = 48,
  parameter int unsigned HEIGHT   = 64,
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_ACTIVE = 600
) (
  input  logic                     clk,
  input  logic                     rst_n,
  vga_if.slave                     vga_in,
  vga_if.master                    vga_out,
  input  logic [N_SPR*POS_W-1:0]   xpos,
  input  logic [N_SPR*POS_W-1:0]   ypos,
  input  logic [N_SPR*RGB_W-1:0]   color,
  input  logic [N_SPR-1:0]         enable,
  output logic [N_SPR-1:0]         coll,
  output logic                     frame_tick
);

  localparam spr_pos_t X_MAX = POS_W'(H_ACTIVE - WIDTH);
  localparam spr_pos_t Y_MAX = POS_W'(V_ACTIVE - HEIGHT);

  logic             prev_vblnk;
  logic             frame_start_c;

  spr_pos_t         sh_x   [N_SPR];
  spr_pos_t         sh_y   [N_SPR];
  rgb_t             sh_col [N_SPR];
  logic [N_SPR-1:0] sh_en;

  logic [N_SPR-1:0] hit_c;
  logic [N_SPR-1:0] hit_q;
  logic [N_SPR-1:0] acc;
  logic             multi_hit_c;
  rgb_t             rgb_sel_c;

  spr_pos_t         s1_hcount;
  spr_pos_t         s1_vcount;
  logic             s1_hsync;
  logic             s1_vsync;
  logic             s1_hblnk;
  logic             s1_vblnk;
  rgb_t             s1_rgb;

  assign frame_start_c = vga_in.vblnk & ~prev_vblnk;

  // Window comparators, one per object.
  for (genvar i = 0; i < N_SPR; i++) begin : g_hit
    sprite_hit #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT)
    ) u_hit (
      .en     (sh_en[i]),
      .hcount (vga_in.hcount),
      .vcount (vga_in.vcount),
      .sx     (sh_x[i]),
      .sy     (sh_y[i]),
      .hblnk  (vga_in.hblnk),
      .vblnk  (vga_in.vblnk),
      .hit_c  (hit_c[i])
    );
  end

  // Vertical-blank edge detector and frame tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_vblnk <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      prev_vblnk <= vga_in.vblnk;
      frame_tick <= frame_start_c;
    end
  end

  // Shadow object state, reloaded only at the start of vertical blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SPR; i++) begin
        sh_x[i]   <= '0;
        sh_y[i]   <= '0;
        sh_col[i] <= '0;
      end
      sh_en <= '0;
    end else if (frame_start_c) begin
      for (int i = 0; i < N_SPR; i++) begin
        sh_x[i]   <= clamp_pos(xpos[i*POS_W +: POS_W], X_MAX);
        sh_y[i]   <= clamp_pos(ypos[i*POS_W +: POS_W], Y_MAX);
        sh_col[i] <= color[i*RGB_W +: RGB_W];
      end
      sh_en <= enable;
    end
  end

  // Stage 1: register hits alongside the incoming raster.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q     <= '0;
      s1_hcount <= '0;
      s1_vcount <= '0;
      s1_hsync  <= 1'b0;
      s1_vsync  <= 1'b0;
      s1_hblnk  <= 1'b0;
      s1_vblnk  <= 1'b0;
      s1_rgb    <= '0;
    end else begin
      hit_q     <= hit_c;
      s1_hcount <= vga_in.hcount;
      s1_vcount <= vga_in.vcount;
      s1_hsync  <= vga_in.hsync;
      s1_vsync  <= vga_in.vsync;
      s1_hblnk  <= vga_in.hblnk;
      s1_vblnk  <= vga_in.vblnk;
      s1_rgb    <= vga_in.rgb;
    end
  end

  // Priority select: lowest-index hit wins, otherwise background passes through.
  always_comb begin
    rgb_sel_c = s1_rgb;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (hit_q[i]) rgb_sel_c = sh_col[i];
    end
  end

  // Two or more simultaneous hits means an overlap on this pixel.
  assign multi_hit_c = |(hit_q & (hit_q - N_SPR'(1)));

  // Stage 2: overlaid output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.hcount <= s1_hcount;
      vga_out.vcount <= s1_vcount;
      vga_out.hsync  <= s1_hsync;
      vga_out.vsync  <= s1_vsync;
      vga_out.hblnk  <= s1_hblnk;
      vga_out.vblnk  <= s1_vblnk;
      vga_out.rgb    <= rgb_sel_c;
    end
  end

  // Collision accumulator; the frame clear takes precedence over accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      coll <= '0;
    end else if (frame_start_c) begin
      coll <= acc;
      acc  <= '0;
    end else if (multi_hit_c) begin
      acc <= acc | hit_q;
    end
  end

endmodule

// File: doc/draw_sprites.md
Name: draw_sprites

Overview:
- Multi-object successor to the single-rectangle drawer. Overlays up to N_SPR solid-colour rectangles on the VGA stream from draw_bg.
- Output goes to the VGA pins or a later overlay stage.
- Per-object positions are double-buffered so they only change during vertical blanking.
- Reports per-object overlap (collision) once per frame for game logic running on clk_40.

Parameters:
N_SPR, 4, number of objects (1..8); index 0 has the highest draw priority.
WIDTH, 48, object width in pixels (all objects).
HEIGHT, 64, object height in pixels (all objects).
H_ACTIVE, 800, visible pixels per line; used for the position clamp.
V_ACTIVE, 600, visible lines per frame; used for the position clamp.

Ports:
clk  in  1  pixel clock (clk_40 domain).
rst_n  in  1  asynchronous active-low reset.
vga_in  in  vga_if  incoming vcount/vsync/vblnk/hcount/hsync/hblnk/rgb.
vga_out  out  vga_if  same fields, delayed 2 cycles, rgb overlaid.
xpos  in  N_SPR*12  requested left edge per object; object i uses bits [12i+11:12i].
ypos  in  N_SPR*12  requested top edge per object.
color  in  N_SPR*12  RGB444 colour per object.
enable  in  N_SPR  object visible when 1.
coll  out  N_SPR  bit i = object i overlapped at least one other enabled object on a visible pixel in the previous frame.
frame_tick  out  1  one-cycle pulse when shadow registers and coll update.

Behaviour:
- Reset (async assert, sync deassert):
  - All vga_out fields, coll and frame_tick are 0.
  - Shadow position, colour and enable registers are 0, so nothing is drawn until the first frame update.
- Frame update: a prev_vblnk register detects the vga_in.vblnk 0→1 edge. On that cycle:
  - Shadow xpos is loaded as min(xpos_i, H_ACTIVE-WIDTH).
  - Shadow ypos is loaded as min(ypos_i, V_ACTIVE-HEIGHT).
  - Shadow colour and enable are loaded.
  - coll is loaded from the accumulator, and the accumulator clears.
  - frame_tick = 1 for exactly that cycle.
- Inputs may change at any time; only the value sampled at the edge is used.
- Stage 1 (registered):
  - hit[i] = sh_en[i] & (hcount >= sx_i) & (hcount < sx_i+WIDTH) & (vcount >= sy_i) & (vcount < sy_i+HEIGHT) & !hblnk & !vblnk.
  - Comparisons are 12-bit unsigned. The sums cannot overflow because the clamp bounds them.
  - All vga_in fields are registered alongside hit.
- Stage 2 (registered):
  - rgb_out = color of the lowest-index set hit bit; if no bit is set, the stage-1 rgb passes through.
  - Timing fields are registered unchanged.
- Total latency is 2 cycles for every field. hsync, vsync, hblnk and vblnk keep their relative alignment exactly.
- Collision accumulation:
  - In any cycle where the stage-1 hit vector has 2 or more bits set, acc |= hit.
  - Hits are zero during blanking, so an accumulate and a clear can never coincide. If they did, the clear would win.
- The accumulator sees stage-1 hits, which trail vga_in by 1 cycle. The vblnk edge on vga_in lands after the last active pixel's hit has been accumulated, so no pixel is lost.
- Reset mid-frame:
  - Outputs drop to 0 immediately.
  - After release, rgb passes through with 2-cycle latency.
  - Objects reappear only after the next vblnk rising edge.
  - coll stays 0 until the second frame_tick after release, because the first tick loads the empty accumulator.
- Single-object, disabled or non-overlapping frames give coll = 0.

Decomposition:
- draw_pkg holds POS_W = 12 and RGB_W = 12, plus a typedef spr_pos_t (logic [11:0]) and a typedef rgb_t (logic [11:0]).
- Sub-module sprite_hit: the combinational window comparison for one object, producing a 1-bit hit. It is instantiated N_SPR times in a generate loop, and the top registers its outputs.
- Priority mux, clamp, accumulator and edge detect stay in draw_sprites.

Test Plan:
- Reset then pass-through: all enable=0, vga_in.rgb=12'h123 → vga_out.rgb=12'h123 and hsync/vsync equal vga_in delayed exactly 2 cycles; coll=0.
- Single object: object 0 at (100,50), colour 12'h0F0, enabled after one frame_tick → green exactly for hcount 100..147, vcount 50..113; pixel 99 and pixel 148 show background.
- Priority and collision: object 0 at (200,200) red 12'hF00, object 1 at (220,220) blue 12'h00F → pixel (230,230) red, pixel (260,260) blue; after the next frame_tick coll=2'b11 (bits 2,3 = 0).
- Clamp and double buffer:
  - Write xpos=790, ypos=590 mid-frame → the current frame is unchanged.
  - Next frame, the object spans x 752..799, y 536..599.
  - frame_tick is one cycle wide, once per frame.
- Reset mid-frame: assert rst_n=0 at vcount=300 for 5 cycles → vga_out all 0 during reset; no object pixels until the next vblnk edge; coll=0 after the first subsequent frame_tick.
